// File: rtl/cache_arb_pkg.sv
// -----------------------------------------------------------------------------
// cache_arb_pkg
//
// Shared types and constants for the two-port cache arbiter.
//   arb_state_t : arbiter FSM state (IDLE -> ISSUE -> RESP -> IDLE)
//   port_id_t   : requester index (0 = instruction fetch, 1 = data)
//   NPORT       : number of requesters, fixed at 2 in this revision
//   other_port  : the requester that is not the given one
// -----------------------------------------------------------------------------
package cache_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    typedef logic port_id_t;

    localparam int NPORT = 2;

    // With exactly two requesters the "other" port is the inverted index.
    function automatic port_id_t other_port(input port_id_t p);
        return ~p;
    endfunction

endpackage

// File: rtl/cache_port_arbiter_grant.sv
// -----------------------------------------------------------------------------
// arb_grant2
//
// Purely combinational grant selection for two requesters.
//
// Configuration macro: CACHE_ARB_RR_EN
//   defined   : round-robin; the port named by 'prefer' wins a tie.
//   undefined : fixed priority, port 0 over port 1; 'prefer' is ignored.
//
// Ports:
//   req[1:0]     in   pending requests, bit i = port i
//   prefer       in   preferred port (round-robin pointer)
//   grant        out  index of the winning port (meaningful when grant_valid)
//   grant_valid  out  at least one port is requesting
// -----------------------------------------------------------------------------
module arb_grant2
    import cache_arb_pkg::*;
(
    input  logic [1:0] req,
    input  port_id_t   prefer,
    output port_id_t   grant,
    output logic       grant_valid
);

    assign grant_valid = |req;

`ifdef CACHE_ARB_RR_EN
    // The preferred port wins if it is asking; otherwise the other one gets
    // the grant (grant_valid tells the caller whether anyone asked at all).
    always_comb begin
        if (req[prefer]) begin
            grant = prefer;
        end else begin
            grant = other_port(prefer);
        end
    end
`else
    // Fixed priority: port 0 whenever it asks, port 1 only when port 0 is idle.
    logic unused_prefer;
    assign unused_prefer = prefer;

    always_comb begin
        if (req[0]) begin
            grant = 1'b0;
        end else begin
            grant = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/cache_port_arbiter.sv
// -----------------------------------------------------------------------------
// cache_port_arbiter
//
// Shares one single-request cache between an instruction-fetch requester
// (port 0) and a data load/store requester (port 1). One transaction is in
// flight at a time: it is latched on acceptance, held on the cache interface
// across any miss/refill, and completed with a one-cycle ack and registered
// read data returned to the owning port.
//
// Configuration macro: CACHE_ARB_RR_EN
//   defined   : two-way round-robin arbitration using a preference pointer
//               that flips to the port not just served on every completion.
//   undefined : fixed priority, port 0 over port 1 (port 1 may starve); the
//               round-robin pointer does not exist.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   pN_req                 request, held with stable fields until pN_ack
//   pN_wr                  1 = write, 0 = read
//   pN_addr / pN_wdata     byte address / write data
//   pN_ack                 one-cycle completion pulse
//   pN_rdata               registered read data, valid with ack and held
//   c_rd_req / c_wr_req    cache read / write request (never both high)
//   c_addr / c_wr_data     cache address / write data
//   c_miss                 cache miss/busy, combinational from the cache
//   c_rd_data              cache read data, registered inside the cache
//   busy                   high whenever the FSM is not IDLE
//
// Timing: accept on edge E0 (IDLE -> ISSUE); a hit completes on E1
// (ISSUE -> RESP, cache registers its read data); on E2 the arbiter captures
// that data and raises the ack, which is visible in the following IDLE
// cycle. Back-to-back requests therefore take 3 cycles each. A requester
// sees its ack during an IDLE cycle and must retire or replace its request
// before the next edge; the arbiter never feeds ack back into the grant.
// -----------------------------------------------------------------------------
module cache_port_arbiter
    import cache_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NPORT  = cache_arb_pkg::NPORT
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              p0_req,
    input  logic              p0_wr,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,

    input  logic              p1_req,
    input  logic              p1_wr,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,

    output logic              c_rd_req,
    output logic              c_wr_req,
    output logic [ADDR_W-1:0] c_addr,
    output logic [DATA_W-1:0] c_wr_data,
    input  logic              c_miss,
    input  logic [DATA_W-1:0] c_rd_data,

    output logic              busy
);

    // -------------------------------------------------------------------------
    // Requester fields gathered into per-port vectors/arrays
    // -------------------------------------------------------------------------
    logic [NPORT-1:0]  req_vec;
    logic [NPORT-1:0]  req_wr;
    logic [ADDR_W-1:0] req_addr  [NPORT];
    logic [DATA_W-1:0] req_wdata [NPORT];

    assign req_vec      = {p1_req, p0_req};
    assign req_wr       = {p1_wr,  p0_wr};
    assign req_addr[0]  = p0_addr;
    assign req_addr[1]  = p1_addr;
    assign req_wdata[0] = p0_wdata;
    assign req_wdata[1] = p1_wdata;

    // -------------------------------------------------------------------------
    // FSM and latched transaction
    // -------------------------------------------------------------------------
    arb_state_t        state_q, state_d;
    port_id_t          owner_q, owner_d;
    logic              wr_q,    wr_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    port_id_t          prefer;
    port_id_t          grant;
    logic              grant_valid;

    arb_grant2 u_grant (
        .req         (req_vec),
        .prefer      (prefer),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            IDLE: begin
                // Capture the winner's fields now; later changes on the
                // requester side are deliberately ignored.
                if (grant_valid) begin
                    owner_d = grant;
                    wr_d    = req_wr[grant];
                    addr_d  = req_addr[grant];
                    wdata_d = req_wdata[grant];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // Stay here for as long as the cache reports miss/busy.
                if (!c_miss) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // -------------------------------------------------------------------------
    // Arbitration preference
    // -------------------------------------------------------------------------
`ifdef CACHE_ARB_RR_EN
    port_id_t rr_q, rr_d;

    // After every completion the port that was not served becomes preferred,
    // so two continuously requesting ports alternate.
    always_comb begin
        rr_d = rr_q;
        if (state_q == RESP) begin
            rr_d = other_port(owner_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end

    assign prefer = rr_q;
`else
    assign prefer = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Cache-side interface: driven only while ISSUE, zero otherwise
    // -------------------------------------------------------------------------
    logic issuing;

    assign issuing   = (state_q == ISSUE);
    assign c_rd_req  = issuing & ~wr_q;
    assign c_wr_req  = issuing &  wr_q;
    assign c_addr    = issuing ? addr_q  : '0;
    assign c_wr_data = issuing ? wdata_q : '0;
    assign busy      = (state_q != IDLE);

    // -------------------------------------------------------------------------
    // Per-port ack pulse and read-data register
    // -------------------------------------------------------------------------
    logic [NPORT-1:0]  ack_vec;
    logic [DATA_W-1:0] rdata_vec [NPORT];

    for (genvar gi = 0; gi < NPORT; gi++) begin : g_port
        logic              served;
        logic              ack_q,   ack_d;
        logic [DATA_W-1:0] rdata_q, rdata_d;

        // c_rd_data was registered by the cache on the ISSUE -> RESP edge,
        // so it is stable throughout RESP and is captured on the RESP edge.
        assign served = (state_q == RESP) && (owner_q == port_id_t'(gi));

        always_comb begin
            ack_d   = served;
            rdata_d = rdata_q;
            if (served && !wr_q) begin
                rdata_d = c_rd_data;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                ack_q   <= 1'b0;
                rdata_q <= '0;
            end else begin
                ack_q   <= ack_d;
                rdata_q <= rdata_d;
            end
        end

        assign ack_vec[gi]   = ack_q;
        assign rdata_vec[gi] = rdata_q;
    end

    assign p0_ack   = ack_vec[0];
    assign p1_ack   = ack_vec[1];
    assign p0_rdata = rdata_vec[0];
    assign p1_rdata = rdata_vec[1];

endmodule
